// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
// State and grant encodings plus the default access latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    localparam int LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// 4-bit loadable down-counter timing the ACCESS phase.
// Ports: clk, rst, load, load_val, dec in; zero flag out.
module wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Ports: ireq/iaddr/iack, dreq/dwe/daddr/dwdata/dack, rdata, mem_* port, busy.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DW  = 8,
    // access cycles per transfer, 1..15
    parameter int LAT = LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic          iack,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic          dack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          memRead,
    output logic          memWrite,
    output logic          busy
);

    state_t state;
    state_t state_nx;
    grant_t grant;
    grant_t last_grant;
    grant_t pick;
    logic   is_wr;
    logic   start;
    logic   zero;

    assign start = (state == IDLE) && (ireq || dreq);
    assign busy  = (state != IDLE);

    // Contention goes to whoever lost the previous grant.
    always_comb begin
        pick = GNT_INST;
        if (ireq && dreq) begin
            pick = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (dreq) begin
            pick = GNT_DATA;
        end
    end

    wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (4'(LAT - 1)),
        .dec      (state == ACCESS),
        .zero     (zero)
    );

    // The write flag is frozen at grant so a requester dropping dreq
    // mid-access cannot turn a write into a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_INST;
            last_grant <= GNT_DATA;
            is_wr      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                grant      <= pick;
                last_grant <= pick;
                is_wr      <= (pick == GNT_DATA) && dwe;
            end
            if (state == ACCESS && zero && !is_wr) begin
                rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iack      = 1'b0;
        dack      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (ireq || dreq) state_nx = ACCESS;
            end
            ACCESS: begin
                memRead  = !is_wr;
                memWrite = is_wr;
                mem_addr = (grant == GNT_DATA) ? daddr : iaddr;
                if (is_wr) mem_wdata = dwdata;
                if (zero) state_nx = DONE;
            end
            DONE: begin
                iack     = (grant == GNT_INST);
                dack     = (grant == GNT_DATA);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked each cycle against a transaction-level timing model.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ireq = 1'b0;
    logic [7:0] iaddr = '0;
    logic       iack;
    logic       dreq = 1'b0;
    logic       dwe = 1'b0;
    logic [7:0] daddr = '0;
    logic [7:0] dwdata = '0;
    logic       dack;
    logic [7:0] rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       memRead;
    logic       memWrite;
    logic       busy;

    logic       ireq1 = 1'b0;
    logic [7:0] iaddr1 = '0;
    logic       iack1;
    logic       dreq1 = 1'b0;
    logic       dwe1 = 1'b0;
    logic [7:0] daddr1 = '0;
    logic [7:0] dwdata1 = '0;
    logic       dack1;
    logic [7:0] rdata1;
    logic [7:0] mem_addr1;
    logic [7:0] mem_wdata1;
    logic [7:0] mem_rdata1 = 8'h77;
    logic       memRead1;
    logic       memWrite1;
    logic       busy1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];

    // model state
    int         act_s = -100;
    bit         last_d = 1'b1;
    bit         m_d;
    bit         m_we;
    logic [7:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] m_val;
    logic [7:0] rd_exp = '0;
    bit         on_i = 1'b0;
    bit         on_d = 1'b0;

    mem_arbiter #(.AW(8), .DW(8), .LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iaddr(iaddr), .iack(iack),
        .dreq(dreq), .dwe(dwe), .daddr(daddr),
        .dwdata(dwdata), .dack(dack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .memRead(memRead),
        .memWrite(memWrite), .busy(busy)
    );

    mem_arbiter #(.AW(8), .DW(8), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ireq(ireq1), .iaddr(iaddr1), .iack(iack1),
        .dreq(dreq1), .dwe(dwe1), .daddr(daddr1),
        .dwdata(dwdata1), .dack(dack1), .rdata(rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .memRead(memRead1),
        .memWrite(memWrite1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = tb_mem[mem_addr];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // memory behind the port
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i * 7 + 3);
        tb_mem[8'h10] = 8'hA5;
        forever begin
            @(posedge clk);
            if (memWrite) tb_mem[mem_addr] = mem_wdata;
        end
    end

    // Reference: a request seen in a free cycle c occupies the port for
    // cycles c+1..c+LAT and acks in cycle c+LAT+1; the port is free
    // again from c+LAT+2. Contention goes to the one not served last.
    initial begin
        bit in_acc;
        bit in_done;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        ref_mem[8'h10] = 8'hA5;
        forever begin
            @(negedge clk);
            if (rst) begin
                act_s  = -100;
                last_d = 1'b1;
                rd_exp = '0;
                on_i   = 1'b0;
                on_d   = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rd", 32'(memRead), 32'd0);
                chk("rst_wr", 32'(memWrite), 32'd0);
                chk("rst_ack", 32'({iack, dack}), 32'd0);
                chk("rst_rdata", 32'(rdata), 32'd0);
            end else begin
                in_acc  = (cyc >= act_s) && (cyc < act_s + LAT);
                in_done = (cyc == act_s + LAT);
                if (in_done) begin
                    if (m_we) ref_mem[m_addr] = m_wd;
                    else rd_exp = m_val;
                    on_i = 1'b0;
                    on_d = 1'b0;
                end
                chk("busy", 32'(busy), 32'(in_acc || in_done));
                chk("memRead", 32'(memRead), 32'(in_acc && !m_we));
                chk("memWrite", 32'(memWrite), 32'(in_acc && m_we));
                chk("iack", 32'(iack), 32'(in_done && !m_d));
                chk("dack", 32'(dack), 32'(in_done && m_d));
                chk("mem_addr", 32'(mem_addr),
                    in_acc ? 32'(m_addr) : 32'd0);
                chk("mem_wdata", 32'(mem_wdata),
                    (in_acc && m_we) ? 32'(m_wd) : 32'd0);
                chk("rdata", 32'(rdata), 32'(rd_exp));
                if (!in_acc && !in_done && (ireq || dreq)) begin
                    m_d    = dreq && (!ireq || !last_d);
                    m_addr = m_d ? daddr : iaddr;
                    m_we   = m_d && dwe;
                    m_wd   = dwdata;
                    m_val  = ref_mem[m_addr];
                    act_s  = cyc + 1;
                    last_d = m_d;
                    on_i   = !m_d;
                    on_d   = m_d;
                end
            end
        end
    end

    task automatic one_shot(input bit d, input logic [7:0] a,
                            input bit we, input logic [7:0] wd,
                            output int ack_at, output int n_ack,
                            output int rds, output int wrs,
                            output logic [7:0] ma,
                            output logic [7:0] mw);
        @(posedge clk); #1;
        if (d) begin
            daddr = a; dwe = we; dwdata = wd; dreq = 1'b1;
        end else begin
            iaddr = a; ireq = 1'b1;
        end
        ack_at = -1; n_ack = 0; rds = 0; wrs = 0;
        ma = '0; mw = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rds += int'(memRead);
            wrs += int'(memWrite);
            if (memWrite) begin
                ma = mem_addr; mw = mem_wdata;
            end
            if (iack || dack) begin
                n_ack++;
                if (ack_at < 0) ack_at = k;
                @(posedge clk); #1;
                ireq = 1'b0; dreq = 1'b0;
            end
        end
        ireq = 1'b0; dreq = 1'b0;
    endtask

    task automatic drive(input bit d, input int n);
        bit hold;
        bit dropped;
        bit got;
        hold = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (!hold) begin
                if (d) dreq = 1'b0; else ireq = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            if (d) begin
                daddr  = 8'($urandom);
                dwdata = 8'($urandom);
                dwe    = 1'($urandom);
                dreq   = 1'b1;
            end else begin
                iaddr = 8'($urandom);
                ireq  = 1'b1;
            end
            dropped = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 60 && !got; k++) begin
                @(negedge clk);
                if (d ? dack : iack) begin
                    got = 1'b1;
                end else if (!dropped && (d ? on_d : on_i)
                             && $urandom_range(0, 3) == 0) begin
                    dropped = 1'b1;
                    @(posedge clk); #1;
                    if (d) dreq = 1'b0; else ireq = 1'b0;
                end
            end
            chk(d ? "d_ack_seen" : "i_ack_seen", 32'(got), 32'd1);
            @(posedge clk); #1;
            hold = !dropped && ($urandom_range(0, 1) == 1);
        end
        if (d) dreq = 1'b0; else ireq = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int ack_at, n_ack, rds, wrs;
        logic [7:0] ma, mw;
        bit seq[$];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_rdata", 32'(rdata), 32'd0);

        // fetch of 0x10, memory holds 0xA5
        one_shot(1'b0, 8'h10, 1'b0, 8'h00,
                 ack_at, n_ack, rds, wrs, ma, mw);
        chk("f_ack_cycle", 32'(ack_at), 32'(LAT + 1));
        chk("f_ack_count", 32'(n_ack), 32'd1);
        chk("f_rd_cycles", 32'(rds), 32'(LAT));
        chk("f_wr_cycles", 32'(wrs), 32'd0);
        chk("f_rdata", 32'(rdata), 32'hA5);

        // data write 0x3C -> 0x20
        one_shot(1'b1, 8'h20, 1'b1, 8'h3C,
                 ack_at, n_ack, rds, wrs, ma, mw);
        chk("w_ack_cycle", 32'(ack_at), 32'(LAT + 1));
        chk("w_ack_count", 32'(n_ack), 32'd1);
        chk("w_wr_cycles", 32'(wrs), 32'(LAT));
        chk("w_rd_cycles", 32'(rds), 32'd0);
        chk("w_addr", 32'(ma), 32'h20);
        chk("w_wdata", 32'(mw), 32'h3C);
        chk("w_rdata_kept", 32'(rdata), 32'hA5);
        chk("w_mem", 32'(tb_mem[8'h20]), 32'h3C);

        // both held continuously from reset
        pulse_rst();
        iaddr = 8'h40; daddr = 8'h41; dwe = 1'b0;
        ireq = 1'b1; dreq = 1'b1;
        for (int k = 0; k < 40 && seq.size() < 4; k++) begin
            @(negedge clk);
            if (iack || dack) seq.push_back(dack);
        end
        @(posedge clk); #1;
        ireq = 1'b0; dreq = 1'b0;
        chk("rr_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++)
            chk("rr_order", 32'(seq[i]), 32'(i % 2));

        // reset in the first ACCESS cycle of a data read
        @(posedge clk); #1;
        daddr = 8'h30; dwe = 1'b0; dreq = 1'b1;
        @(posedge clk); #1;
        chk("ra_rd_before", 32'(memRead), 32'd1);
        rst = 1'b1;
        #1;
        chk("ra_rd_drop", 32'(memRead), 32'd0);
        chk("ra_busy_drop", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dreq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("ra_no_dack", 32'(dack), 32'd0);
        end
        one_shot(1'b1, 8'h30, 1'b0, 8'h00,
                 ack_at, n_ack, rds, wrs, ma, mw);
        chk("ra_ack_cycle", 32'(ack_at), 32'(LAT + 1));
        chk("ra_rdata", 32'(rdata), 32'(ref_mem[8'h30]));

        // LAT=1 instance, fetch dropped during ACCESS
        @(posedge clk); #1;
        iaddr1 = 8'h44; ireq1 = 1'b1;
        @(posedge clk); #1;
        ireq1 = 1'b0;
        chk("l1_rd", 32'(memRead1), 32'd1);
        chk("l1_addr", 32'(mem_addr1), 32'h44);
        @(negedge clk);
        chk("l1_no_ack_c1", 32'(iack1), 32'd0);
        @(negedge clk);
        chk("l1_ack_c2", 32'(iack1), 32'd1);
        chk("l1_busy_c2", 32'(busy1), 32'd1);
        @(negedge clk);
        chk("l1_ack_c3", 32'(iack1), 32'd0);
        chk("l1_busy_c3", 32'(busy1), 32'd0);
        chk("l1_rdata", 32'(rdata1), 32'h77);
        chk("l1_quiet",
            32'({dack1, memWrite1, memRead1, mem_wdata1}), 32'd0);

        // randomized contention
        fork
            drive(1'b0, 60);
            drive(1'b1, 60);
        join
        repeat (6) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
